// File: rtl/fetch_decode_pipe_regs_pkg.sv
// Shared definitions for the fetch/decode pipeline register bank.
// Reset defaults, next-PC select encodings and control-bundle bit positions.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_ALU    = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_e;

    localparam int CTRL_W_DEF    = 10;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // Only the two execute-stage targets count as a redirect; the reserved code falls back to PC+4.
    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PCSRC_TARGET) || (src == PCSRC_ALU);
    endfunction

endpackage

// File: rtl/fetch_decode_pipe_regs_if.sv
// Bundle of hazard controls, stage data and pipeline-register outputs.
// The slave side is the register bank, the master side is the surrounding core.
interface fetch_decode_pipe_regs_if #(
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEF,
    parameter int CNT_W  = 32
);
    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        PCSrcE;
    logic [31:0]       PCTargetE, ALUResultE;
    logic [31:0]       InstrF;
    logic [31:0]       RD1D, RD2D, ImmExtD;
    logic [CTRL_W-1:0] CtrlD;
    logic              cnt_clr;

    logic [31:0]       PCF;
    logic [31:0]       InstrD, PCD, PCPlus4D;
    logic              ValidD, ValidE;
    logic [4:0]        Rs1E, Rs2E, RdE;
    logic [31:0]       RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [CTRL_W-1:0] CtrlE;
    logic [CNT_W-1:0]  StallCnt, FlushCnt;

    modport slave (
        input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, ALUResultE,
               InstrF, RD1D, RD2D, ImmExtD, CtrlD, cnt_clr,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, ValidE, Rs1E, Rs2E, RdE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, CtrlE, StallCnt, FlushCnt
    );

    modport master (
        output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, ALUResultE,
               InstrF, RD1D, RD2D, ImmExtD, CtrlD, cnt_clr,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, ValidE, Rs1E, Rs2E, RdE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, CtrlE, StallCnt, FlushCnt
    );
endinterface

// File: rtl/fetch_decode_pipe_regs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// One cycle from condition to visible count; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_decode_pipe_regs.sv
// PC, IF/ID and ID/EX registers driven by the hazard unit's stall/flush controls.
// One cycle per stage; StallF/StallD hold, FlushD/FlushE insert bubbles, redirects override StallF.
module fetch_decode_pipe_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CTRL_W    = CTRL_W_DEF,
    parameter int          CNT_W     = 32
) (
    input logic clk,
    input logic rst_n,
    fetch_decode_pipe_regs_if.slave bus
);
    logic [31:0] pcf_q, pcf_d, pc_plus4f, pc_next;
    ifid_t       ifid_q, ifid_d;

    logic [31:0]       rd1e_q, rd1e_d, rd2e_q, rd2e_d, immexte_q, immexte_d;
    logic [31:0]       pce_q, pce_d, pcplus4e_q, pcplus4e_d;
    logic [4:0]        rs1e_q, rs1e_d, rs2e_q, rs2e_d, rde_q, rde_d;
    logic [CTRL_W-1:0] ctrle_q, ctrle_d;
    logic              valide_q, valide_d;

    assign pc_plus4f = pcf_q + 32'd4;

    always_comb begin
        pc_next = pc_plus4f;
        case (bus.PCSrcE)
            PCSRC_TARGET: pc_next = bus.PCTargetE;
            PCSRC_ALU:    pc_next = bus.ALUResultE;
            default:      pc_next = pc_plus4f;
        endcase
        pcf_d = (!bus.StallF || is_redirect(bus.PCSrcE)) ? pc_next : pcf_q;
    end

    always_comb begin
        ifid_d = ifid_q;
        if (bus.FlushD) begin
            ifid_d = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
        end else if (!bus.StallD) begin
            ifid_d = '{instr: bus.InstrF, pc: pcf_q, pc_plus4: pc_plus4f, valid: 1'b1};
        end
    end

    // Register fields come from the instruction currently held in D, so a bubble yields x0 everywhere.
    always_comb begin
        rd1e_d     = bus.RD1D;
        rd2e_d     = bus.RD2D;
        immexte_d  = bus.ImmExtD;
        pce_d      = ifid_q.pc;
        pcplus4e_d = ifid_q.pc_plus4;
        rs1e_d     = ifid_q.instr[19:15];
        rs2e_d     = ifid_q.instr[24:20];
        rde_d      = ifid_q.instr[11:7];
        ctrle_d    = bus.CtrlD;
        valide_d   = ifid_q.valid;
        if (bus.FlushE) begin
            rd1e_d     = '0;
            rd2e_d     = '0;
            immexte_d  = '0;
            pce_d      = '0;
            pcplus4e_d = '0;
            rs1e_d     = '0;
            rs2e_d     = '0;
            rde_d      = '0;
            ctrle_d    = '0;
            valide_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q      <= RESET_PC;
            ifid_q     <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
            rd1e_q     <= '0;
            rd2e_q     <= '0;
            immexte_q  <= '0;
            pce_q      <= '0;
            pcplus4e_q <= '0;
            rs1e_q     <= '0;
            rs2e_q     <= '0;
            rde_q      <= '0;
            ctrle_q    <= '0;
            valide_q   <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            ifid_q     <= ifid_d;
            rd1e_q     <= rd1e_d;
            rd2e_q     <= rd2e_d;
            immexte_q  <= immexte_d;
            pce_q      <= pce_d;
            pcplus4e_q <= pcplus4e_d;
            rs1e_q     <= rs1e_d;
            rs2e_q     <= rs2e_d;
            rde_q      <= rde_d;
            ctrle_q    <= ctrle_d;
            valide_q   <= valide_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bus.StallD),
        .clr_i (bus.cnt_clr),
        .cnt_o (bus.StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bus.FlushE),
        .clr_i (bus.cnt_clr),
        .cnt_o (bus.FlushCnt)
    );

    assign bus.PCF      = pcf_q;
    assign bus.InstrD   = ifid_q.instr;
    assign bus.PCD      = ifid_q.pc;
    assign bus.PCPlus4D = ifid_q.pc_plus4;
    assign bus.ValidD   = ifid_q.valid;
    assign bus.ValidE   = valide_q;
    assign bus.Rs1E     = rs1e_q;
    assign bus.Rs2E     = rs2e_q;
    assign bus.RdE      = rde_q;
    assign bus.RD1E     = rd1e_q;
    assign bus.RD2E     = rd2e_q;
    assign bus.ImmExtE  = immexte_q;
    assign bus.PCE      = pce_q;
    assign bus.PCPlus4E = pcplus4e_q;
    assign bus.CtrlE    = ctrle_q;
endmodule

// File: tb/tb_fetch_decode_pipe_regs.sv
// Directed bench for the pipeline register bank, built with 4-bit counters so saturation is reachable.
module tb_fetch_decode_pipe_regs;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 4;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I1  = 32'h0020_8133;  // add  x2,x1,x2
    localparam logic [31:0] I2  = 32'h0030_A183;  // lw   x3,3(x1)
    localparam logic [31:0] I3  = 32'h0010_0213;  // addi x4,x0,1
    localparam logic [31:0] I4  = 32'h0000_0513;  // addi x10,x0,0
    localparam logic [31:0] I5  = 32'h0000_0093;  // addi x1,x0,0

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_decode_pipe_regs_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    fetch_decode_pipe_regs #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .CTRL_W    (CTRL_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sf, sd, fd, fe;
        logic [1:0]  src;
        logic [31:0] tgt, alu, instr;
        logic [9:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] pcf, instrd, pcd, pcp4d;
        logic        vd, ve;
        logic [4:0]  rs1e, rs2e, rde;
        logic [9:0]  ctrle;
        logic [31:0] rd1e, pce, pcp4e;
        logic [3:0]  scnt, fcnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic fe,
                         input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                         input logic [31:0] instr, input logic [9:0] ctrl, input logic [31:0] rd1);
        bus.StallF     = sf;
        bus.StallD     = sd;
        bus.FlushD     = fd;
        bus.FlushE     = fe;
        bus.PCSrcE     = src;
        bus.PCTargetE  = tgt;
        bus.ALUResultE = alu;
        bus.InstrF     = instr;
        bus.CtrlD      = ctrl;
        bus.RD1D       = rd1;
        bus.RD2D       = rd1 << 4;
        bus.ImmExtD    = rd1 << 8;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{0,0,0,0,2'b00,32'h0,32'h0,I0,10'h001,32'h11,
                    32'h4,I0,32'h0,32'h4,1,0,5'd0,5'd0,5'd0,10'h001,32'h11,32'h0,32'h0,4'd0,4'd0};
        vecs[1] = '{0,0,0,0,2'b00,32'h0,32'h0,I1,10'h001,32'h22,
                    32'h8,I1,32'h4,32'h8,1,1,5'd0,5'd5,5'd1,10'h001,32'h22,32'h0,32'h4,4'd0,4'd0};
        vecs[2] = '{1,1,0,1,2'b00,32'h0,32'h0,I2,10'h001,32'h33,
                    32'h8,I1,32'h4,32'h8,1,0,5'd0,5'd0,5'd0,10'h000,32'h0,32'h0,32'h0,4'd1,4'd1};
        vecs[3] = '{0,0,0,0,2'b00,32'h0,32'h0,I2,10'h001,32'h44,
                    32'hC,I2,32'h8,32'hC,1,1,5'd1,5'd2,5'd2,10'h001,32'h44,32'h4,32'h8,4'd1,4'd1};
        vecs[4] = '{0,0,1,1,2'b01,32'h40,32'h0,32'hDEAD_BEEF,10'h002,32'h55,
                    32'h40,NOP,32'h0,32'h0,0,0,5'd0,5'd0,5'd0,10'h000,32'h0,32'h0,32'h0,4'd1,4'd2};
        vecs[5] = '{0,0,0,0,2'b00,32'h0,32'h0,I3,10'h001,32'h66,
                    32'h44,I3,32'h40,32'h44,1,0,5'd0,5'd0,5'd0,10'h001,32'h66,32'h0,32'h0,4'd1,4'd2};
        vecs[6] = '{1,0,0,1,2'b10,32'h0,32'h100,I4,10'h001,32'h77,
                    32'h100,I4,32'h44,32'h48,1,0,5'd0,5'd0,5'd0,10'h000,32'h0,32'h0,32'h0,4'd1,4'd3};
        vecs[7] = '{1,1,0,0,2'b00,32'h0,32'h0,32'h1234_5678,10'h003,32'h88,
                    32'h100,I4,32'h44,32'h48,1,1,5'd0,5'd0,5'd10,10'h003,32'h88,32'h44,32'h48,4'd2,4'd3};
        vecs[8] = '{0,0,0,0,2'b11,32'h200,32'h300,I5,10'h000,32'h99,
                    32'h104,I5,32'h100,32'h104,1,1,5'd0,5'd0,5'd10,10'h000,32'h99,32'h44,32'h48,4'd2,4'd3};

        rst_n       = 1'b0;
        bus.cnt_clr = 1'b0;
        drive(0,0,0,0,2'b00,32'h0,32'h0,I0,10'h001,32'h11);
        #12;
        chk("rst.pcf",    bus.PCF,    32'h0);
        chk("rst.instrd", bus.InstrD, NOP);
        chk("rst.validd", 32'(bus.ValidD), 32'h0);
        chk("rst.valide", 32'(bus.ValidE), 32'h0);
        chk("rst.ctrle",  32'(bus.CtrlE),  32'h0);
        chk("rst.scnt",   32'(bus.StallCnt), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].fe, vecs[i].src,
                  vecs[i].tgt, vecs[i].alu, vecs[i].instr, vecs[i].ctrl, vecs[i].rd1);
            tick();
            chk($sformatf("v%0d.pcf", i),    bus.PCF,      vecs[i].pcf);
            chk($sformatf("v%0d.instrd", i), bus.InstrD,   vecs[i].instrd);
            chk($sformatf("v%0d.pcd", i),    bus.PCD,      vecs[i].pcd);
            chk($sformatf("v%0d.pcp4d", i),  bus.PCPlus4D, vecs[i].pcp4d);
            chk($sformatf("v%0d.validd", i), 32'(bus.ValidD), 32'(vecs[i].vd));
            chk($sformatf("v%0d.valide", i), 32'(bus.ValidE), 32'(vecs[i].ve));
            chk($sformatf("v%0d.rs1e", i),   32'(bus.Rs1E),   32'(vecs[i].rs1e));
            chk($sformatf("v%0d.rs2e", i),   32'(bus.Rs2E),   32'(vecs[i].rs2e));
            chk($sformatf("v%0d.rde", i),    32'(bus.RdE),    32'(vecs[i].rde));
            chk($sformatf("v%0d.ctrle", i),  32'(bus.CtrlE),  32'(vecs[i].ctrle));
            chk($sformatf("v%0d.rd1e", i),   bus.RD1E,     vecs[i].rd1e);
            chk($sformatf("v%0d.rd2e", i),   bus.RD2E,     vecs[i].rd1e << 4);
            chk($sformatf("v%0d.immexte", i), bus.ImmExtE, vecs[i].rd1e << 8);
            chk($sformatf("v%0d.pce", i),    bus.PCE,      vecs[i].pce);
            chk($sformatf("v%0d.pcp4e", i),  bus.PCPlus4E, vecs[i].pcp4e);
            chk($sformatf("v%0d.scnt", i),   32'(bus.StallCnt), 32'(vecs[i].scnt));
            chk($sformatf("v%0d.fcnt", i),   32'(bus.FlushCnt), 32'(vecs[i].fcnt));
        end

        // PC wrap-around at the top of the address space
        drive(0,0,0,0,2'b01,32'hFFFF_FFFC,32'h0,I0,10'h001,32'h1);
        tick();
        chk("wrap.pcf0", bus.PCF, 32'hFFFF_FFFC);
        drive(0,0,0,0,2'b00,32'h0,32'h0,I1,10'h001,32'h1);
        tick();
        chk("wrap.pcf1",  bus.PCF,      32'h0);
        chk("wrap.pcd",   bus.PCD,      32'hFFFF_FFFC);
        chk("wrap.pcp4d", bus.PCPlus4D, 32'h0);

        // Stall counter saturation, F and D held throughout
        drive(1,1,0,0,2'b00,32'h0,32'h0,I2,10'h001,32'h1);
        for (int n = 0; n < 20; n++) tick();
        chk("sat.scnt", 32'(bus.StallCnt), 32'hF);
        chk("sat.fcnt", 32'(bus.FlushCnt), 32'h3);
        chk("sat.pcf",  bus.PCF, 32'h0);
        chk("sat.pcd",  bus.PCD, 32'hFFFF_FFFC);

        drive(1,0,0,1,2'b00,32'h0,32'h0,I2,10'h001,32'h1);
        for (int n = 0; n < 20; n++) tick();
        chk("satf.fcnt", 32'(bus.FlushCnt), 32'hF);
        chk("satf.scnt", 32'(bus.StallCnt), 32'hF);

        // Clear has priority over a simultaneous increment
        drive(1,1,0,1,2'b00,32'h0,32'h0,I2,10'h001,32'h1);
        bus.cnt_clr = 1'b1;
        tick();
        chk("clr.scnt", 32'(bus.StallCnt), 32'h0);
        chk("clr.fcnt", 32'(bus.FlushCnt), 32'h0);
        bus.cnt_clr = 1'b0;
        drive(1,1,0,0,2'b00,32'h0,32'h0,I2,10'h001,32'h1);
        tick();
        chk("post.scnt", 32'(bus.StallCnt), 32'h1);
        chk("post.fcnt", 32'(bus.FlushCnt), 32'h0);

        // Asynchronous reset between edges
        drive(0,0,0,0,2'b00,32'h0,32'h0,I3,10'h3FF,32'hABCD);
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.pcf",    bus.PCF,    32'h0);
        chk("arst.instrd", bus.InstrD, NOP);
        chk("arst.pcd",    bus.PCD,    32'h0);
        chk("arst.validd", 32'(bus.ValidD), 32'h0);
        chk("arst.valide", 32'(bus.ValidE), 32'h0);
        chk("arst.rde",    32'(bus.RdE),    32'h0);
        chk("arst.ctrle",  32'(bus.CtrlE),  32'h0);
        chk("arst.rd1e",   bus.RD1E,   32'h0);
        chk("arst.scnt",   32'(bus.StallCnt), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rel.pcf",    bus.PCF,    32'h4);
        chk("rel.instrd", bus.InstrD, I3);
        chk("rel.validd", 32'(bus.ValidD), 32'h1);
        chk("rel.valide", 32'(bus.ValidE), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_pipe_regs.md
# fetch_decode_pipe_regs

Pipeline-register bank that consumes the hazard unit's StallF/StallD/FlushD/FlushE outputs and applies them. It holds the PC register, the IF/ID register and the ID/EX register, plus the next-PC select. It also keeps valid bits per stage and saturating stall/flush performance counters. It sits between the instruction memory / register file / decoder and the execute stage of the 5-stage RISC-V core.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into InstrD on reset/flush
- CTRL_W, 10, width of packed decoder control bundle
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallF, StallD, FlushD, FlushE  in  1 each  hazard-unit controls
- PCSrcE  in  2  00 PC+4, 01 PCTargetE, 10 ALUResultE, 11 reserved (treated as 00)
- PCTargetE, ALUResultE  in  32  redirect targets from execute
- InstrF  in  32  instruction-memory read data for PCF
- RD1D, RD2D, ImmExtD  in  32  register-file data and extended immediate
- CtrlD  in  CTRL_W  decoder control bundle; bit0 = RegWrite, bit1 = MemWrite
- cnt_clr  in  1  synchronous clear of both counters
- PCF  out  32  fetch PC
- InstrD, PCD, PCPlus4D  out  32  IF/ID contents
- ValidD, ValidE  out  1  stage holds a real instruction
- Rs1E, Rs2E, RdE  out  5  register fields (InstrD[19:15], [24:20], [11:7])
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32  ID/EX data
- CtrlE  out  CTRL_W  ID/EX control bundle
- StallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- PC register: next PC = PCF+4 / PCTargetE / ALUResultE per PCSrcE. Loaded unless StallF=1. A redirect (PCSrcE 01 or 10) loads even when StallF=1; the redirect wins.
- IF/ID register: priority FlushD > StallD > load.
  - Flush: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Stall: all fields hold.
  - Load: InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
- ID/EX register: has no stall. FlushE=1 loads a bubble: every field 0 (CtrlE=0, so RegWrite=0 and MemWrite=0), ValidE=0. Otherwise it captures D-stage values, with ValidE=ValidD.
- Rs1E/Rs2E/RdE are always sliced from the InstrD value being captured. A bubble gives 0 for all three, so no forwarding matches.
- StallCnt increments on every cycle with StallD=1. FlushCnt increments on every cycle with FlushE=1. Both saturate at all-ones.
- cnt_clr zeroes both counters and has priority over increment in the same cycle.
- PC arithmetic is 32-bit modulo: PCF 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (rst_n=0, asynchronous): PCF=RESET_PC, InstrD=NOP_INSTR, ValidD=0, ValidE=0, and every other output 0. Reset asserted mid-operation discards all in-flight state immediately.
- The first fetch after deassertion is at RESET_PC. ValidD=1 one cycle later, ValidE=1 two cycles later.
- Load-use stall (StallF=StallD=FlushE=1, one cycle): PCF and IF/ID hold, and E receives one bubble. Normal flow resumes the next cycle.
- Taken branch (PCSrcE=01, FlushD=FlushE=1): the next edge loads PCF=PCTargetE and bubbles both D and E. The first target instruction is in D one cycle after that.
- PCSrcE=10 with FlushE only: D is not flushed and loads normally.
- Counters update on the same edge as the triggering condition; their values are visible the following cycle.

## Structure
- Shared package `pipe_pkg`:
  - NOP_INSTR and RESET_PC defaults
  - PCSrc encodings (PCSRC_PLUS4=2'b00, PCSRC_TARGET=2'b01, PCSRC_ALU=2'b10)
  - CTRL_W and its bit indices
- One natural sub-module: `sat_counter`, parameterized by width, with inc and clr inputs. It is instantiated twice.

## Test plan
- Reset: hold rst_n=0, release with InstrF=32'h0050_0093 -> PCF=0, then 4, then 8 on successive edges; InstrD=32'h0050_0093 with ValidD=1 after the first edge.
- Load-use: StallF=StallD=FlushE=1 for one cycle at PCF=8 -> PCF stays 8, InstrD unchanged, CtrlE=0, RdE=0, ValidE=0, StallCnt=1.
- Branch: PCSrcE=01, PCTargetE=32'h40, FlushD=FlushE=1 -> PCF=32'h40, InstrD=32'h13, ValidD=0, ValidE=0, FlushCnt increments.
- Redirect beats stall: StallF=1 with PCSrcE=10, ALUResultE=32'h100 -> PCF=32'h100.
- Counter edge cases: with StallCnt forced near saturation (CNT_W=4 build), 20 stall cycles -> StallCnt=4'hF. cnt_clr together with StallD=1 -> StallCnt=0.
- Async reset mid-stream: drop rst_n between edges -> all outputs reach their reset values before the next clk edge; PCF=RESET_PC.
